move_scheduler: RTL and testbench

Sequences snake movement from decoded button directions. Takes the 3-bit direction code from `keyboard`, filters it into a short queue of legal turns, and issues one handshaked step per `STEP_CYCLES` interval to the game-state logic. It sits between `keyboard` and the board/VGA update logic and owns run/pause/stop control.

---
 rtl/move_pkg.sv | 30 +++
 rtl/move_scheduler_dir_fifo.sv | 67 ++++++
 rtl/move_scheduler.sv | 146 ++++++++++++++
 tb/tb_move_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// move_pkg: direction codes, scheduler state encodings and direction helper
// functions. The direction constants are shared with the keyboard decoder and
// the downstream game-state logic.
package move_pkg;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_RIGHT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  function automatic logic is_valid(input logic [2:0] code);
    return (code == DIR_UP) || (code == DIR_DOWN) ||
           (code == DIR_LEFT) || (code == DIR_RIGHT);
  endfunction

  // True when a and b point in opposite directions on the same axis.
  function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
    return (a == DIR_UP    && b == DIR_DOWN)  || (a == DIR_DOWN  && b == DIR_UP) ||
           (a == DIR_LEFT  && b == DIR_RIGHT) || (a == DIR_RIGHT && b == DIR_LEFT);
  endfunction

endpackage

// File: rtl/move_scheduler_dir_fifo.sv
// dir_fifo: DEPTH x 3-bit circular buffer of queued turns.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       enqueue din (accepted when not full, or when full and popping)
//   pop             dequeue head (ignored when empty)
//   flush           empty the queue; has priority over push/pop
//   head, tail      oldest and newest entries (meaningful when not empty)
//   count           number of entries, 0..DEPTH
//   full, empty     status flags
module dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [2:0]               din,
  output logic [2:0]               head,
  output logic [2:0]               tail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd_en;
  logic          wr_en;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - PW'(1)];

  // NOTE: storage has no reset; entries are only read once count says they
  // were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: filters keyboard direction codes into a queue of legal
// turns and issues one handshaked step every STEP_CYCLES clocks.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   way               direction code from keyboard (000 = no key)
//   start/pause/stop  one-cycle control pulses
//   step_ready        consumer accepts the pending step
//   step_valid        step pending
//   step_dir          direction of the pending or last step
//   state             00 IDLE, 01 RUN, 10 WAIT, 11 PAUSE
//   queue_cnt         number of queued turns
//   error             pulse on an invalid code event
//   overflow          pulse when a legal turn is dropped on a full queue
module move_scheduler
  import move_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int CNT_W       = 25,
  parameter int QDEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                way,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      stop,
  input  logic                      step_ready,
  output logic                      step_valid,
  output logic [2:0]                step_dir,
  output logic [1:0]                state,
  output logic [$clog2(QDEPTH):0]   queue_cnt,
  output logic                      error,
  output logic                      overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       way_q;
  logic [2:0]       cur_dir;

  logic [2:0] q_head, q_tail;
  logic       q_full, q_empty;

  logic       take_evt, code_ok, legal, wrap, do_pop, ovf_now;
  logic [2:0] ref_dir, next_dir;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    take_evt = 1'b0;
    code_ok  = 1'b0;
    ref_dir  = cur_dir;
    legal    = 1'b0;
    wrap     = 1'b0;
    do_pop   = 1'b0;
    next_dir = cur_dir;
    ovf_now  = 1'b0;

    // Edge on the key code; stop and PAUSE swallow it.
    take_evt = (way != way_q) && (way != DIR_NONE) && !stop && (state_q != ST_PAUSE);
    code_ok  = is_valid(way);
    // New turns are judged against the last direction the snake will have
    // taken before them: the newest queued turn, else the current heading.
    if (!q_empty) ref_dir = q_tail;
    legal = take_evt && code_ok && (way != ref_dir) && !is_reverse(way, ref_dir);

    // A pause on the wrap cycle wins: the count freezes at LAST and the step
    // issues on the first RUN cycle after resuming.
    wrap   = (state_q == ST_RUN) && !pause && !stop && (cnt == LAST);
    do_pop = wrap && !q_empty;
    if (do_pop) next_dir = q_head;
    ovf_now = legal && q_full && !do_pop;
  end

  dir_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (legal),
    .pop   (do_pop),
    .flush (stop),
    .din   (way),
    .head  (q_head),
    .tail  (q_tail),
    .count (queue_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt        <= '0;
      way_q      <= DIR_NONE;
      cur_dir    <= DIR_RIGHT;
      step_dir   <= DIR_RIGHT;
      step_valid <= 1'b0;
      error      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      way_q    <= way;
      error    <= take_evt && !code_ok;
      overflow <= ovf_now;
      if (stop) begin
        state_q    <= ST_IDLE;
        cnt        <= '0;
        step_valid <= 1'b0;
        cur_dir    <= DIR_RIGHT;
        step_dir   <= DIR_RIGHT;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            cnt <= '0;
            if (start) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSE;
            end else if (wrap) begin
              cnt        <= '0;
              cur_dir    <= next_dir;
              step_dir   <= next_dir;
              step_valid <= 1'b1;
              state_q    <= ST_WAIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_WAIT: begin
            if (step_ready) begin
              step_valid <= 1'b0;
              state_q    <= ST_RUN;
            end
          end
          ST_PAUSE: begin
            if (pause) state_q <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with STEP_CYCLES=4, QDEPTH=4.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] way;
  logic       start, pause, stop, step_ready;
  logic       step_valid;
  logic [2:0] step_dir;
  logic [1:0] state;
  logic [2:0] queue_cnt;
  logic       error, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  move_scheduler #(.STEP_CYCLES(4), .CNT_W(3), .QDEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .way        (way),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .step_ready (step_ready),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .state      (state),
    .queue_cnt  (queue_cnt),
    .error      (error),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until step_valid is seen; returns the number of ticks (bounded).
  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_valid && n < 50);
  endtask

  int n;
  int seen;

  initial begin
    rst_n = 1'b0; way = 3'b000; start = 1'b0; pause = 1'b0; stop = 1'b0;
    step_ready = 1'b0;
    #12;
    check("rst_valid",    32'(step_valid), 32'd0);
    check("rst_dir",      32'(step_dir),   32'h6);
    check("rst_state",    32'(state),      32'd0);
    check("rst_qcnt",     32'(queue_cnt),  32'd0);
    check("rst_error",    32'(error),      32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    rst_n = 1'b1;
    tick();

    // 1: free-running steps, ready high: valid one cycle in every five.
    step_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("t1_run", 32'(state), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t1_valid_%0d", i), 32'(step_valid), (i % 5 == 4) ? 32'd1 : 32'd0);
      if (i % 5 == 4) check($sformatf("t1_dir_%0d", i), 32'(step_dir), 32'h6);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("t1_stop_idle", 32'(state), 32'd0);

    // 2: queue UP then LEFT in IDLE, steps come out in order.
    way = 3'b001; tick();
    check("t2_q1", 32'(queue_cnt), 32'd1);
    way = 3'b000; tick();
    way = 3'b010; tick();
    check("t2_q2", 32'(queue_cnt), 32'd2);
    way = 3'b000; tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_step(n);
    check("t2_lat1", 32'(n), 32'd4);
    check("t2_dir1", 32'(step_dir), 32'h1);
    check("t2_qpop", 32'(queue_cnt), 32'd1);
    wait_step(n);
    check("t2_lat2", 32'(n), 32'd5);
    check("t2_dir2", 32'(step_dir), 32'h2);
    check("t2_qempty", 32'(queue_cnt), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;

    // 3: reverse and repeat of RIGHT are silently dropped.
    way = 3'b010; tick();
    check("t3_rev_q", 32'(queue_cnt), 32'd0);
    check("t3_rev_err", 32'(error), 32'd0);
    way = 3'b000; tick();
    way = 3'b110; tick();
    check("t3_same_q", 32'(queue_cnt), 32'd0);
    check("t3_same_err", 32'(error), 32'd0);
    way = 3'b000; tick();

    // 5: invalid code gives one error pulse.
    way = 3'b111; tick();
    check("t5_err", 32'(error), 32'd1);
    check("t5_q", 32'(queue_cnt), 32'd0);
    tick();
    check("t5_err_once", 32'(error), 32'd0);
    way = 3'b000; tick();

    // 4: fill the queue, fifth turn overflows.
    step_ready = 1'b0;
    way = 3'b001; tick();
    way = 3'b010; tick();
    way = 3'b011; tick();
    way = 3'b110; tick();
    check("t4_full", 32'(queue_cnt), 32'd4);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    way = 3'b001; tick();
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_full2", 32'(queue_cnt), 32'd4);
    way = 3'b000; tick();
    check("t4_ovf_once", 32'(overflow), 32'd0);
    // Push UP on the wrap cycle (tail is RIGHT): the pop makes room.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    way = 3'b001; tick(); way = 3'b000;
    check("t4_pop_no_ovf", 32'(overflow), 32'd0);
    check("t4_pop_q", 32'(queue_cnt), 32'd4);
    check("t4_pop_valid", 32'(step_valid), 32'd1);
    check("t4_pop_dir", 32'(step_dir), 32'h1);
    tick(); tick();
    check("t4_hold_valid", 32'(step_valid), 32'd1);
    check("t4_hold_state", 32'(state), 32'd2);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t4_flush", 32'(queue_cnt), 32'd0);

    // 6: pause at count 2, keys ignored while paused, resume, stop in WAIT.
    start = 1'b1; tick(); start = 1'b0;
    way = 3'b001; tick(); way = 3'b000;
    check("t6_q1", 32'(queue_cnt), 32'd1);
    tick();
    pause = 1'b1; tick(); pause = 1'b0;
    check("t6_paused", 32'(state), 32'd3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      way = (i == 5) ? 3'b010 : 3'b000;
      tick();
      if (step_valid) seen++;
    end
    way = 3'b000;
    check("t6_no_step", 32'(seen), 32'd0);
    check("t6_still_paused", 32'(state), 32'd3);
    check("t6_key_dropped", 32'(queue_cnt), 32'd1);
    pause = 1'b1; tick(); pause = 1'b0;
    check("t6_resumed", 32'(state), 32'd1);
    wait_step(n);
    check("t6_lat", 32'(n), 32'd2);
    check("t6_dir", 32'(step_dir), 32'h1);
    pause = 1'b1; tick(); pause = 1'b0;
    check("t6_wait_pause_ign", 32'(state), 32'd2);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t6_stop_state", 32'(state), 32'd0);
    check("t6_stop_valid", 32'(step_valid), 32'd0);
    check("t6_stop_q", 32'(queue_cnt), 32'd0);
    check("t6_stop_dir", 32'(step_dir), 32'h6);

    // Asynchronous reset in WAIT drops the step before the next edge.
    way = 3'b001; tick(); way = 3'b000;
    start = 1'b1; tick(); start = 1'b0;
    wait_step(n);
    check("ar_valid_before", 32'(step_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(step_valid), 32'd0);
    check("ar_state", 32'(state), 32'd0);
    check("ar_dir", 32'(step_dir), 32'h6);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
